// File: rtl/demux_frame_router.sv
// Frame router that feeds the 1-to-4 demux. A start-framed serial stream carries
// a 2-bit channel address followed by PAYLOAD_LEN payload bits for that channel.
module demux_frame_router #(
  parameter int PAYLOAD_LEN = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din,
  output logic             x,
  output logic             s1,
  output logic             s0,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BEAT_W = $clog2(PAYLOAD_LEN) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PAYLOAD_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR_HI = 2'd1,
    ADDR_LO = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic              addr_hi, addr_hi_nxt;
  logic              x_nxt, s1_nxt, s0_nxt, done_nxt, overrun_nxt;
  logic [CNT_W-1:0]  frame_cnt_nxt;

  assign busy = (state != IDLE);

  // x stays low outside PAYLOAD so a following frame's address bits never leak
  always_comb begin
    state_nxt     = state;
    beat_nxt      = beat;
    addr_hi_nxt   = addr_hi;
    x_nxt         = 1'b0;
    s1_nxt        = s1;
    s0_nxt        = s0;
    done_nxt      = 1'b0;
    overrun_nxt   = start && (state != IDLE);
    frame_cnt_nxt = frame_cnt;
    case (state)
      IDLE: begin
        if (start) state_nxt = ADDR_HI;
      end
      ADDR_HI: begin
        addr_hi_nxt = din;
        state_nxt   = ADDR_LO;
      end
      ADDR_LO: begin
        // both selects switch on one edge, never showing a half-updated address
        s1_nxt    = addr_hi;
        s0_nxt    = din;
        beat_nxt  = '0;
        state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        x_nxt    = din;
        beat_nxt = beat + BEAT_W'(1);
        if (beat == LAST_BEAT) begin
          state_nxt     = IDLE;
          done_nxt      = 1'b1;
          frame_cnt_nxt = frame_cnt + CNT_W'(1);
          beat_nxt      = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      addr_hi   <= 1'b0;
      x         <= 1'b0;
      s1        <= 1'b0;
      s0        <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      beat      <= beat_nxt;
      addr_hi   <= addr_hi_nxt;
      x         <= x_nxt;
      s1        <= s1_nxt;
      s0        <= s0_nxt;
      done      <= done_nxt;
      overrun   <= overrun_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

endmodule

// File: doc/demux_frame_router.md
Name: demux_frame_router

Overview:
- Upstream control stage for the 1-to-4 demultiplexer.
- Receives a serial, start-framed bit stream. Each frame is a 2-bit channel address followed by PAYLOAD_LEN payload bits.
- Drives the demux data input (x) and selects (s1, s0) so each payload bit lands on the addressed output y0..y3.
- Also reports busy, frame-done, overrun and a frame count.

Parameters:
- PAYLOAD_LEN, 8: payload bits per frame; legal range >= 1.
- CNT_W, 8: width of frame_cnt.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame start strobe; din is ignored in the start cycle.
- din  input  1  serial address/payload bit, sampled every clock edge.
- x  output  1  data to demux x; registered.
- s1  output  1  demux select MSB; registered.
- s0  output  1  demux select LSB; registered.
- busy  output  1  high whenever state is not IDLE; decoded from the state register.
- done  output  1  one-cycle pulse, coincident with the last payload bit on x.
- overrun  output  1  one-cycle pulse when start is seen while busy.
- frame_cnt  output  CNT_W  completed-frame count; wraps.

Behaviour:
- Reset: one clock is taken with rst=1.
  - All outputs are forced to 0 and state goes to IDLE.
  - The beat counter is cleared and frame_cnt is 0.
  - rst has priority over every other input.
- States: IDLE, ADDR_HI, ADDR_LO, PAYLOAD.
- IDLE:
  - x<=0 on every edge.
  - start=1 -> ADDR_HI. Otherwise stay in IDLE.
  - s1/s0 hold the last frame's address; they are harmless because x=0.
- ADDR_HI:
  - din is captured into an internal addr_hi shadow. s1/s0 are unchanged.
  - -> ADDR_LO.
- ADDR_LO:
  - s1<=addr_hi and s0<=din on the same edge, so the selects never show a half-updated address.
  - The beat counter is cleared. -> PAYLOAD.
- PAYLOAD:
  - On each edge x<=din, so each payload bit appears on x exactly one cycle after it is applied, for exactly one cycle.
  - The beat counter increments each cycle.
  - On the PAYLOAD_LEN-th payload cycle: -> IDLE, done<=1 and frame_cnt<=frame_cnt+1 (mod 2^CNT_W).
  - The cycle after that, IDLE drives x<=0.
- Latency: from the start cycle T, the selects are valid from T+3. Payload bit k appears on x at T+4+k.
- Back-to-back frames:
  - State is already IDLE in the cycle done=1, so start in that cycle is accepted.
  - This gives a zero-gap frame train. The new frame's address does not disturb x, because x<=0 while in ADDR_HI/ADDR_LO.
- start while busy:
  - Ignored; the current frame is unaffected.
  - overrun pulses high for one cycle per offending cycle.
- PAYLOAD_LEN=1: PAYLOAD lasts one cycle; done asserts at T+4.
- Beat counter width: $clog2(PAYLOAD_LEN)+1. It is never compared beyond PAYLOAD_LEN-1.
- Reset mid-frame:
  - The partial frame is discarded. No done pulse and no frame_cnt increment.
  - Outputs return to their reset values the cycle after rst.
- done and overrun are never asserted outside the conditions above.

Test Plan:
- Frame: start at cycle 0, din=1,0 in cycles 1-2, payload 1,0,1,1,0,0,1,1 in cycles 3-10.
  - s1s0=10 from cycle 3.
  - x = 1,0,1,1,0,0,1,1 in cycles 4-11; x=0 at cycle 12.
  - done=1 only at cycle 11; busy=1 in cycles 1-10; frame_cnt=1.
- Four frames back-to-back (start asserted in each done cycle), addresses 00, 01, 10, 11, payload 0xFF.
  - Each address gets 8 consecutive x=1 cycles.
  - Between frames, x=0 for exactly 3 cycles (the done-cycle start and the address phase).
  - frame_cnt=4.
- start pulsed at cycle 6 of a frame.
  - overrun=1 at cycle 7 only.
  - The frame completes unchanged with done at cycle 11; no second frame begins.
- rst asserted at cycle 7 of a frame.
  - At cycle 8: x, s1, s0, busy, done = 0 and frame_cnt=0.
  - Stray din afterwards without start leaves x=0.
- PAYLOAD_LEN=1, CNT_W=2: run 5 frames with address 11 and payload 1.
  - Each frame shows x=1 one cycle after the payload bit, with done in the same cycle.
  - frame_cnt sequence is 1,2,3,0,1.
